// File: rtl/control_pipe.sv
// control_pipe: pipelined decode control for a 5-stage datapath.
// Decodes the ID-stage opcode into EX/MEM/WB control bundles and carries them
// through the ID/EX, EX/MEM and MEM/WB control registers. It also detects
// load-use hazards and inserts a bubble, raises the IF/ID flush for taken
// branches and jumps, and keeps a saturating count of illegal opcodes.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   opCode      ID-stage opcode
//   id_rs/id_rt ID-stage register specifiers
//   id_eq       ID-stage comparator result (rs == rt)
//   ex_ctrl     {regDest, aluOp, aluSrc} from ID/EX
//   ex_rt       rt held in ID/EX
//   mem_ctrl    {branch, memRead, memWrite} from EX/MEM
//   wb_ctrl     {regWrite, memToReg} from MEM/WB
//   stall       load-use hazard (combinational)
//   pc_write    ~stall
//   ifid_write  ~stall
//   if_flush    flush IF/ID (combinational)
//   illegal_cnt saturating illegal-opcode count
module control_pipe #(
   parameter int unsigned OPCODE_W   = 6,
   parameter int unsigned REG_W      = 5,
   parameter int unsigned ALUOP_W    = 2,
   parameter int unsigned ENABLE_EXT = 1,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [OPCODE_W-1:0]  opCode,
   input  logic [REG_W-1:0]     id_rs,
   input  logic [REG_W-1:0]     id_rt,
   input  logic                 id_eq,
   output logic [ALUOP_W+1:0]   ex_ctrl,
   output logic [REG_W-1:0]     ex_rt,
   output logic [2:0]           mem_ctrl,
   output logic [1:0]           wb_ctrl,
   output logic                 stall,
   output logic                 pc_write,
   output logic                 ifid_write,
   output logic                 if_flush,
   output logic [CNT_W-1:0]     illegal_cnt
);

   localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
   localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
   localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
   localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
   localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b000101);
   localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
   localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);

   localparam logic [ALUOP_W-1:0]  ALU_ADD  = ALUOP_W'(2'b00);
   localparam logic [ALUOP_W-1:0]  ALU_SUB  = ALUOP_W'(2'b01);
   localparam logic [ALUOP_W-1:0]  ALU_FUNC = ALUOP_W'(2'b10);

   localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
   localparam logic                EXT_ON   = (ENABLE_EXT != 0);

   // decoded ID-stage control
   logic                w_regdest;
   logic [ALUOP_W-1:0]  w_aluop;
   logic                w_alusrc;
   logic                w_branch;
   logic                w_memread;
   logic                w_memwrite;
   logic                w_regwrite;
   logic                w_memtoreg;
   logic                w_illegal;
   logic                w_jump;
   logic                w_beq;
   logic                w_bne;
   logic                w_hazard;

   // ID/EX control register
   logic                r_idex_regdest;
   logic [ALUOP_W-1:0]  r_idex_aluop;
   logic                r_idex_alusrc;
   logic                r_idex_branch;
   logic                r_idex_memread;
   logic                r_idex_memwrite;
   logic                r_idex_regwrite;
   logic                r_idex_memtoreg;
   logic [REG_W-1:0]    r_idex_rt;

   // EX/MEM control register
   logic                r_exmem_branch;
   logic                r_exmem_memread;
   logic                r_exmem_memwrite;
   logic                r_exmem_regwrite;
   logic                r_exmem_memtoreg;

   // MEM/WB control register
   logic                r_memwb_regwrite;
   logic                r_memwb_memtoreg;

   logic [CNT_W-1:0]    r_illegal_cnt;

   // Opcode decode; extension opcodes fall through to illegal when disabled
   always_comb begin
      w_regdest  = 1'b0;
      w_aluop    = ALU_ADD;
      w_alusrc   = 1'b0;
      w_branch   = 1'b0;
      w_memread  = 1'b0;
      w_memwrite = 1'b0;
      w_regwrite = 1'b0;
      w_memtoreg = 1'b0;
      w_illegal  = 1'b0;
      w_jump     = 1'b0;
      w_beq      = 1'b0;
      w_bne      = 1'b0;
      case (opCode)
         OP_R: begin
            w_regdest  = 1'b1;
            w_aluop    = ALU_FUNC;
            w_regwrite = 1'b1;
         end
         OP_LW: begin
            w_alusrc   = 1'b1;
            w_memread  = 1'b1;
            w_regwrite = 1'b1;
            w_memtoreg = 1'b1;
         end
         OP_SW: begin
            w_alusrc   = 1'b1;
            w_memwrite = 1'b1;
         end
         OP_BEQ: begin
            w_aluop  = ALU_SUB;
            w_branch = 1'b1;
            w_beq    = 1'b1;
         end
         OP_BNE: begin
            if (EXT_ON) begin
               w_aluop  = ALU_SUB;
               w_branch = 1'b1;
               w_bne    = 1'b1;
            end else begin
               w_illegal = 1'b1;
            end
         end
         OP_ADDI: begin
            if (EXT_ON) begin
               w_alusrc   = 1'b1;
               w_regwrite = 1'b1;
            end else begin
               w_illegal = 1'b1;
            end
         end
         OP_J: begin
            if (EXT_ON) begin
               w_jump = 1'b1;
            end else begin
               w_illegal = 1'b1;
            end
         end
         default: w_illegal = 1'b1;
      endcase
   end

   // Load-use hazard: a load in EX whose destination feeds the ID instruction
   assign w_hazard = ~reset & r_idex_memread & (r_idex_rt != '0) &
                     ((r_idex_rt == id_rs) | (r_idex_rt == id_rt));

   assign stall      = w_hazard;
   assign pc_write   = ~w_hazard;
   assign ifid_write = ~w_hazard;

   // Compare operands are stale during a stall, so the flush waits a cycle
   assign if_flush = ~reset & ~w_hazard &
                     (w_jump | (w_beq & id_eq) | (w_bne & ~id_eq));

   // ID/EX: bubble on stall, otherwise the decoded bundle
   always_ff @(posedge clk) begin
      if (reset || w_hazard) begin
         r_idex_regdest  <= 1'b0;
         r_idex_aluop    <= '0;
         r_idex_alusrc   <= 1'b0;
         r_idex_branch   <= 1'b0;
         r_idex_memread  <= 1'b0;
         r_idex_memwrite <= 1'b0;
         r_idex_regwrite <= 1'b0;
         r_idex_memtoreg <= 1'b0;
         r_idex_rt       <= '0;
      end else begin
         r_idex_regdest  <= w_regdest;
         r_idex_aluop    <= w_aluop;
         r_idex_alusrc   <= w_alusrc;
         r_idex_branch   <= w_branch;
         r_idex_memread  <= w_memread;
         r_idex_memwrite <= w_memwrite;
         r_idex_regwrite <= w_regwrite;
         r_idex_memtoreg <= w_memtoreg;
         r_idex_rt       <= id_rt;
      end
   end

   // EX/MEM and MEM/WB advance every cycle regardless of stall
   always_ff @(posedge clk) begin
      if (reset) begin
         r_exmem_branch   <= 1'b0;
         r_exmem_memread  <= 1'b0;
         r_exmem_memwrite <= 1'b0;
         r_exmem_regwrite <= 1'b0;
         r_exmem_memtoreg <= 1'b0;
         r_memwb_regwrite <= 1'b0;
         r_memwb_memtoreg <= 1'b0;
      end else begin
         r_exmem_branch   <= r_idex_branch;
         r_exmem_memread  <= r_idex_memread;
         r_exmem_memwrite <= r_idex_memwrite;
         r_exmem_regwrite <= r_idex_regwrite;
         r_exmem_memtoreg <= r_idex_memtoreg;
         r_memwb_regwrite <= r_exmem_regwrite;
         r_memwb_memtoreg <= r_exmem_memtoreg;
      end
   end

   // Illegal opcode counter; a stalled opcode is counted once it proceeds
   always_ff @(posedge clk) begin
      if (reset) begin
         r_illegal_cnt <= '0;
      end else if (w_illegal && !w_hazard && (r_illegal_cnt != CNT_MAX)) begin
         r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
      end
   end

   assign ex_ctrl     = {r_idex_regdest, r_idex_aluop, r_idex_alusrc};
   assign ex_rt       = r_idex_rt;
   assign mem_ctrl    = {r_exmem_branch, r_exmem_memread, r_exmem_memwrite};
   assign wb_ctrl     = {r_memwb_regwrite, r_memwb_memtoreg};
   assign illegal_cnt = r_illegal_cnt;

endmodule
